// File: rtl/app_port_arbiter.sv
// app_port_arbiter: round-robin, burst-bounded arbiter of per-app AMI requests onto one registered downstream port.
// Define APP_ARB_STATS_EN to add per-app accepted-request counters (stats_clear / grant_count).
package ami_pkg;
  localparam int AMI_NUM_APPS = 4;
  localparam int AMI_APP_BITS = 3;
  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
    logic [5:0]  size;
  } AMIRequest;
endpackage

module app_port_arbiter
  import ami_pkg::*;
#(
  parameter int NUM_APPS  = AMI_NUM_APPS,
  parameter int BURST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef APP_ARB_STATS_EN
  input  logic                    stats_clear,
  output logic [31:0]             grant_count [NUM_APPS],
`endif
  input  logic [NUM_APPS-1:0]     app_en,
  input  AMIRequest               inReq [NUM_APPS],
  output logic [NUM_APPS-1:0]     reqAccepted,
  output AMIRequest               outReq,
  input  logic                    outReq_grant,
  output logic [AMI_APP_BITS-1:0] out_app,
  output logic                    busy
);
  typedef enum logic {IDLE, OWNED} arb_state_t;
  localparam logic [AMI_APP_BITS-1:0] LAST_RST = AMI_APP_BITS'(NUM_APPS - 1);
  localparam logic [3:0] BMAX = 4'(BURST_MAX);
  arb_state_t arb_state, arb_state_nx;
  logic [AMI_APP_BITS-1:0] owner, owner_nx, last_app, last_app_nx, base, win, hi_win, lo_win;
  logic [3:0] burst_cnt, burst_cnt_nx;
  logic [NUM_APPS-1:0] elig;
  logic slot_free, owner_elig, stay, hi_found, lo_found, grant_any;
  AMIRequest sel;
  always_ff @(posedge clk) begin
    if (rst) begin
      arb_state <= IDLE;
      owner     <= '0;
      last_app  <= LAST_RST;
      burst_cnt <= '0;
    end else begin
      arb_state <= arb_state_nx;
      owner     <= owner_nx;
      last_app  <= last_app_nx;
      burst_cnt <= burst_cnt_nx;
    end
  end
  // Wrapped scan from base+1: lowest eligible above base, else lowest at or below base.
  always_comb begin
    elig       = '0;
    owner_elig = 1'b0;
    hi_found   = 1'b0;
    lo_found   = 1'b0;
    hi_win     = '0;
    lo_win     = '0;
    base       = arb_state == OWNED ? owner : last_app;
    for (int i = NUM_APPS - 1; i >= 0; i--) begin
      elig[i] = app_en[i] && inReq[i].valid;
      if (elig[i] && AMI_APP_BITS'(i) == owner) owner_elig = 1'b1;
      if (elig[i] && AMI_APP_BITS'(i) > base) begin
        hi_found = 1'b1;
        hi_win   = AMI_APP_BITS'(i);
      end
      if (elig[i] && AMI_APP_BITS'(i) <= base) begin
        lo_found = 1'b1;
        lo_win   = AMI_APP_BITS'(i);
      end
    end
    slot_free    = !outReq.valid || outReq_grant;
    stay         = arb_state == OWNED && owner_elig && burst_cnt < BMAX;
    grant_any    = slot_free && (stay || hi_found || lo_found);
    win          = stay ? owner : hi_found ? hi_win : lo_win;
    reqAccepted  = grant_any ? NUM_APPS'(1) << win : '0;
    arb_state_nx = arb_state;
    owner_nx     = owner;
    last_app_nx  = last_app;
    burst_cnt_nx = burst_cnt;
    if (slot_free) begin
      last_app_nx  = arb_state == OWNED && !stay ? owner : last_app;
      arb_state_nx = grant_any ? OWNED : IDLE;
      owner_nx     = grant_any ? win : owner;
      burst_cnt_nx = stay ? burst_cnt + 4'd1 : grant_any ? 4'd1 : 4'd0;
    end
  end
  always_comb begin
    sel = inReq[0];
    for (int i = 1; i < NUM_APPS; i++)
      if (AMI_APP_BITS'(i) == win) sel = inReq[i];
  end
  // Buffer holds while the downstream stalls; only valid drops on an empty decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      outReq  <= '0;
      out_app <= '0;
    end else if (slot_free) begin
      if (grant_any) begin
        outReq  <= sel;
        out_app <= win;
      end else
        outReq.valid <= 1'b0;
    end
  end
  assign busy = outReq.valid || |elig;
`ifdef APP_ARB_STATS_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_APPS; i++)
      grant_count[i] <= (rst || stats_clear) ? 32'd0 : grant_count[i] + 32'(reqAccepted[i]);
  end
`endif
endmodule
